// File: rtl/wb_multi.sv
// Multi-lane writeback stage: bundle FIFO feeding LANES register-file write ports.
// Optional retired-instruction counter is compiled in when WB_TRACE_EN is defined.
module wb_multi #(
    parameter int LANES = 2,
    parameter int DEPTH = 2,
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   mem2wb_valid_i,
    output logic                   mem2wb_ready_o,
    input  logic [LANES-1:0]       lane_valid_i,
    input  logic [LANES-1:0]       lane_we_i,
    input  logic [LANES*RADDR-1:0] lane_wdest_i,
    input  logic [LANES*XLEN-1:0]  lane_wdata_i,
    input  logic [LANES*XLEN-1:0]  lane_pc_i,
    input  logic                   wb_stall_i,
    output logic [LANES-1:0]       rf_we_o,
    output logic [LANES*RADDR-1:0] rf_wdest_o,
    output logic [LANES*XLEN-1:0]  rf_wdata_o,
    output logic [LANES*RADDR-1:0] ctl_wb_dest_o,
    output logic [LANES*XLEN-1:0]  ctl_wb_pc_o,
    output logic                   ctl_wb_over_o,
    output logic [31:0]            retired_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [LANES-1:0]       r_valid [DEPTH];
    logic [LANES-1:0]       r_we    [DEPTH];
    logic [LANES*RADDR-1:0] r_dest  [DEPTH];
    logic [LANES*XLEN-1:0]  r_data  [DEPTH];
    logic [LANES*XLEN-1:0]  r_pc    [DEPTH];
    logic [PW-1:0]          r_wptr;
    logic [PW-1:0]          r_rptr;
    logic [CW-1:0]          r_count;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_nonEmpty;
    logic [LANES-1:0]       w_hValid;
    logic [LANES-1:0]       w_hWe;
    logic [LANES*RADDR-1:0] w_hDest;
    logic [LANES*XLEN-1:0]  w_hData;
    logic [LANES*XLEN-1:0]  w_hPc;
    logic [LANES-1:0]       w_kill;

    // Ready depends only on registered occupancy, never on the stall input.
    assign mem2wb_ready_o = (r_count != CW'(DEPTH));
    assign w_push         = mem2wb_valid_i & mem2wb_ready_o;
    assign w_nonEmpty     = (r_count != '0);
    assign w_pop          = w_nonEmpty & ~wb_stall_i;
    assign ctl_wb_over_o  = w_pop;

    assign w_hValid = r_valid[r_rptr];
    assign w_hWe    = r_we[r_rptr];
    assign w_hDest  = r_dest[r_rptr];
    assign w_hData  = r_data[r_rptr];
    assign w_hPc    = r_pc[r_rptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= '0;
                r_we[i]    <= '0;
                r_dest[i]  <= '0;
                r_data[i]  <= '0;
                r_pc[i]    <= '0;
            end
        end else begin
            if (w_push) begin
                r_valid[r_wptr] <= lane_valid_i;
                r_we[r_wptr]    <= lane_we_i;
                r_dest[r_wptr]  <= lane_wdest_i;
                r_data[r_wptr]  <= lane_wdata_i;
                r_pc[r_wptr]    <= lane_pc_i;
                r_wptr          <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // An older lane is killed when a younger lane in the bundle writes the same register.
    always_comb begin
        w_kill = '0;
        for (int k = 0; k < LANES; k++) begin
            for (int j = k + 1; j < LANES; j++) begin
                if (w_hValid[j] && w_hWe[j] &&
                    (w_hDest[j*RADDR +: RADDR] == w_hDest[k*RADDR +: RADDR]) &&
                    (w_hDest[k*RADDR +: RADDR] != '0)) begin
                    w_kill[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rf_we_o       = '0;
        rf_wdest_o    = '0;
        rf_wdata_o    = '0;
        ctl_wb_dest_o = '0;
        ctl_wb_pc_o   = '0;
        for (int k = 0; k < LANES; k++) begin
            if (w_nonEmpty) begin
                rf_wdest_o[k*RADDR +: RADDR] = w_hDest[k*RADDR +: RADDR];
                rf_wdata_o[k*XLEN +: XLEN]   = w_hData[k*XLEN +: XLEN];
                ctl_wb_pc_o[k*XLEN +: XLEN]  = w_hPc[k*XLEN +: XLEN];
                if (w_hValid[k]) begin
                    ctl_wb_dest_o[k*RADDR +: RADDR] = w_hDest[k*RADDR +: RADDR];
                end
            end
            rf_we_o[k] = w_pop & w_hValid[k] & w_hWe[k] &
                         (w_hDest[k*RADDR +: RADDR] != '0) & ~w_kill[k];
        end
    end

`ifdef WB_TRACE_EN
    logic [31:0] r_retired;
    logic [31:0] w_popCnt;

    // Counts every valid head lane, including killed and non-writing ones.
    always_comb begin
        w_popCnt = '0;
        for (int k = 0; k < LANES; k++) begin
            w_popCnt = w_popCnt + 32'(w_hValid[k]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_retired <= '0;
        end else if (w_pop) begin
            r_retired <= r_retired + w_popCnt;
        end
    end

    assign retired_cnt_o = r_retired;
`else
    assign retired_cnt_o = '0;
`endif

endmodule
